// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight writes over DEPTH stages and the mult/div
// busy counter, producing the Decode stall and per-port forwarding selects.
module hazard_scoreboard #(
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned TNEW_W   = 2,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      issue_valid_i,
   input  logic [NUM_RD*5-1:0]       rs_addr_i,
   input  logic [NUM_RD*TNEW_W-1:0]  tuse_i,
   input  logic [4:0]                dst_addr_i,
   input  logic [TNEW_W-1:0]         dst_tnew_i,
   input  logic                      md_start_i,
   input  logic                      md_is_div_i,
   input  logic                      md_use_i,
   input  logic                      flush_i,
   output logic                      stall_o,
   output logic [NUM_RD*SEL_W-1:0]   fwd_sel_o,
   output logic                      md_busy_o
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   typedef struct packed {
      logic              valid;
      logic [4:0]        dst;
      logic [TNEW_W-1:0] tnew;
   } entry_t;

   entry_t          ent_q [DEPTH];
   entry_t          ent_d [DEPTH];
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            hazard;
   logic            found;
   logic [4:0]      rs;
   logic [TNEW_W-1:0] tu;
   logic            accept;

   // Youngest valid match per port decides both stall and forward select.
   always_comb begin
      hazard    = 1'b0;
      fwd_sel_o = '0;
      found     = 1'b0;
      rs        = '0;
      tu        = '0;
      for (int p = 0; p < int'(NUM_RD); p++) begin
         found = 1'b0;
         rs    = rs_addr_i[5*p +: 5];
         tu    = tuse_i[TNEW_W*p +: TNEW_W];
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (!found && rs != 5'd0 && ent_q[k].valid && ent_q[k].dst == rs) begin
               found = 1'b1;
               if (ent_q[k].tnew > tu) hazard = 1'b1;
               if (ent_q[k].tnew == '0) fwd_sel_o[SEL_W*p +: SEL_W] = SEL_W'(k + 1);
            end
         end
      end
      if (md_use_i && cnt_q != '0) hazard = 1'b1;
      stall_o = issue_valid_i && hazard && !reset_i;
      if (reset_i) fwd_sel_o = '0;
   end

   assign md_busy_o = (cnt_q != '0) && !reset_i;
   assign accept    = issue_valid_i && !stall_o && !flush_i;

   always_comb begin
      ent_d[0] = '0;
      if (accept && dst_addr_i != 5'd0) begin
         ent_d[0].valid = 1'b1;
         ent_d[0].dst   = dst_addr_i;
         ent_d[0].tnew  = dst_tnew_i;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
         ent_d[k] = ent_q[k-1];
         if (ent_q[k-1].tnew != '0) ent_d[k].tnew = ent_q[k-1].tnew - 1'b1;
      end
      cnt_d = cnt_q;
      if (accept && md_start_i) begin
         cnt_d = md_is_div_i ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k < int'(DEPTH); k++) ent_q[k] <= '0;
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) ent_q[k] <= ent_d[k];
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus mult/div and reset sequences.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       issue_valid;
   logic [9:0] rs_addr;
   logic [3:0] tuse;
   logic [4:0] dst_addr;
   logic [1:0] dst_tnew;
   logic       md_start, md_is_div, md_use, flush;
   logic       stall;
   logic [3:0] fwd_sel;
   logic       md_busy;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .issue_valid_i (issue_valid),
      .rs_addr_i     (rs_addr),
      .tuse_i        (tuse),
      .dst_addr_i    (dst_addr),
      .dst_tnew_i    (dst_tnew),
      .md_start_i    (md_start),
      .md_is_div_i   (md_is_div),
      .md_use_i      (md_use),
      .flush_i       (flush),
      .stall_o       (stall),
      .fwd_sel_o     (fwd_sel),
      .md_busy_o     (md_busy)
   );

   typedef struct {
      logic       iv;
      logic [4:0] rs0;
      logic [1:0] tu0;
      logic [4:0] rs1;
      logic [1:0] tu1;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic       mds, mdd, mdu, fl;
      logic       e_stall;
      logic [1:0] e_f0, e_f1;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic iv, logic [4:0] rs0, logic [1:0] tu0, logic [4:0] rs1,
                               logic [1:0] tu1, logic [4:0] dst, logic [1:0] tnew, logic mds,
                               logic mdd, logic mdu, logic fl, logic st, logic [1:0] f0,
                               logic [1:0] f1, logic busy);
      vec_t v;
      v.iv = iv; v.rs0 = rs0; v.tu0 = tu0; v.rs1 = rs1; v.tu1 = tu1; v.dst = dst;
      v.tnew = tnew; v.mds = mds; v.mdd = mdd; v.mdu = mdu; v.fl = fl;
      v.e_stall = st; v.e_f0 = f0; v.e_f1 = f1; v.e_busy = busy;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(vec_t v);
      issue_valid = v.iv;
      rs_addr     = {v.rs1, v.rs0};
      tuse        = {v.tu1, v.tu0};
      dst_addr    = v.dst;
      dst_tnew    = v.tnew;
      md_start    = v.mds;
      md_is_div   = v.mdd;
      md_use      = v.mdu;
      flush       = v.fl;
   endtask

   task automatic idle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   // Issues one mult/div, then holds an HI/LO consumer in Decode and counts stall cycles.
   task automatic md_seq(logic is_div, int exp_cycles);
      int n;
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 0, 0, 0, 1, is_div, 1, 0, 0, 0, 0, 0));
      #1 chk("md_issue_stall", 32'(stall), 0);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
         #1;
         if (i == 0) chk("md_busy_first", 32'(md_busy), 1);
         if (!stall) break;
         n++;
      end
      chk(is_div ? "div_stall_cycles" : "mult_stall_cycles", 32'(n), 32'(exp_cycles));
      chk("md_busy_after", 32'(md_busy), 0);
   endtask

   initial begin
      // Forwarding from E, M, W and retirement of an ALU result.
      vecs.push_back(mk(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
      vecs.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Load-use: two stalls then forward from W.
      vecs.push_back(mk(1, 0, 0, 0, 0, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
      vecs.push_back(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Youngest match wins; r0 never matches.
      vecs.push_back(mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
      // Younger not-ready producer hides an older ready one.
      vecs.push_back(mk(1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 6, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 6, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));
      // Stall plus flush loads a bubble; hazard without issue_valid does not stall.
      vecs.push_back(mk(1, 0, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 0, 0, 0, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 4, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Flushed md_start leaves the counter idle.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

      idle();
      #2;
      chk("reset_stall", 32'(stall), 0);
      chk("reset_fwd", 32'(fwd_sel), 0);
      chk("reset_busy", 32'(md_busy), 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d_fwd", i), 32'(fwd_sel), 32'({vecs[i].e_f1, vecs[i].e_f0}));
         chk($sformatf("v%0d_busy", i), 32'(md_busy), 32'(vecs[i].e_busy));
      end

      md_seq(1'b1, 10);
      md_seq(1'b0, 5);

      // Reset mid-operation: div in flight (count 7) and r8 in all three stages.
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(mk(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      @(negedge clk);
      drive(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      #1;
      chk("pre_rst_stall", 32'(stall), 1);
      chk("pre_rst_fwd", 32'(fwd_sel), 1);
      chk("pre_rst_busy", 32'(md_busy), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_stall", 32'(stall), 0);
      chk("mid_rst_fwd", 32'(fwd_sel), 0);
      chk("mid_rst_busy", 32'(md_busy), 0);
      @(negedge clk);
      reset = 1'b0;
      drive(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      #1;
      chk("post_rst_fwd", 32'(fwd_sel), 0);
      chk("post_rst_busy", 32'(md_busy), 0);
      @(negedge clk);
      drive(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      #1;
      chk("post_rst_edge_fwd", 32'(fwd_sel), 0);
      chk("post_rst_edge_stall", 32'(stall), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed forwarding-select logic: tracks in-flight register writes across DEPTH pipeline stages after Decode.
- Per cycle, produces a stall request and a per-read-port forward-stage select for the instruction in Decode.
- Adds a multi-cycle mult/div busy counter that stalls HI/LO consumers.
- Sits beside the Decode stage and drives the pipeline-register enables and the Decode forwarding muxes.

Parameters:
NUM_RD, 2, number of Decode read ports checked
DEPTH, 3, tracked stages after Decode (1=E, 2=M, 3=W)
TNEW_W, 2, width of Tnew/Tuse fields
MULT_LAT, 5, busy cycles loaded for a multiply
DIV_LAT, 10, busy cycles loaded for a divide
SEL_W, clog2(DEPTH+1), width of each forward select

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  Decode holds a real instruction
rs_addr  in  NUM_RD*5  source register per port, port p at bits [5p+4:5p]
tuse  in  NUM_RD*TNEW_W  cycles until port p's value is consumed
dst_addr  in  5  destination register of the Decode instruction (0 = none)
dst_tnew  in  TNEW_W  cycles after entering E until the result exists
md_start  in  1  Decode instruction starts mult (0) / div (1)
md_is_div  in  1  selects DIV_LAT when md_start
md_use  in  1  Decode instruction reads or writes HI/LO or starts mult/div
flush  in  1  kill the Decode instruction this cycle
stall  out  1  freeze F/D; insert bubble into E
fwd_sel  out  NUM_RD*SEL_W  per port: 0 = register file, k = forward from stage k
md_busy  out  1  mult/div counter non-zero

Behaviour:
- State: DEPTH entries {valid, dst[4:0], tnew[TNEW_W-1:0]} plus a busy counter wide enough for max(MULT_LAT, DIV_LAT).
- Async reset: all entries valid=0, dst=0, tnew=0; counter=0. While reset is high: stall=0, fwd_sel=0, md_busy=0.
- Every clock edge, independent of stall:
  - Entry k+1 <= entry k, with tnew decremented and saturating at 0.
  - Entry DEPTH is discarded; the register file writes it that edge.
- Entry 1 on an edge:
  - Loads {1, dst_addr, dst_tnew} iff issue_valid && !stall && !flush && dst_addr!=0.
  - Otherwise loads a bubble (valid=0).
  - flush beats stall when both are asserted.
- Match for port p: rs_addr_p!=0 and a valid entry with dst==rs_addr_p. Only the youngest match (lowest k) counts; older matches are ignored.
- Data hazard, port p: youngest match has tnew > tuse_p -> stall=1.
- fwd_sel_p:
  - = k if the youngest match is at stage k with tnew==0.
  - = 0 if there is no match, or the match has tnew!=0. In the latter case the consumer is covered later by downstream forwarding.
- Register 0 never matches, never stalls and never forwards.
- MD hazard: md_use && counter!=0 -> stall=1.
- Busy counter:
  - On an edge with md_start && issue_valid && !stall && !flush, it loads MULT_LAT (md_is_div=0) or DIV_LAT (md_is_div=1).
  - Otherwise it decrements when non-zero.
  - md_busy = (counter!=0).
- stall = OR of all port hazards and the MD hazard, gated by issue_valid. It is combinational from inputs and current state, with zero latency.
- Simultaneous hazards on several ports: a single stall. fwd_sel is still driven for the non-stalling ports.
- Reset mid-operation: all in-flight entries and the busy count are lost immediately. The first post-reset cycle sees no hazards.

Test Plan:
- Reset with entries loaded and counter=7 -> immediately stall=0, fwd_sel=0, md_busy=0; on the next edge entries remain invalid.
- Issue dst=8 tnew=0 (ALU), then a consumer with rs_addr0=8, tuse=0 -> stall=0, fwd_sel0=1; next cycle fwd_sel0=2, then 3, then 0.
- Issue load dst=9 tnew=2, then a consumer rs_addr0=9 tuse=0 -> stall for 2 cycles, then fwd_sel0=3 (W) on the third cycle.
- Stage 1 and stage 2 both hold dst=5 (tnew 0); port 1 reads 5 -> fwd_sel1=1 (youngest wins); a read of r0 with a matching dst=0 request -> fwd_sel=0, no stall.
- md_start with md_is_div=1 -> md_busy for 10 cycles; an mflo (md_use) issued next -> stall for exactly 10 cycles; a mult variant gives 5.
- stall and flush together with dst=4 -> entry 1 loads a bubble, no later match on r4; md_start with flush leaves the counter unchanged.
